// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the 4:1 mux.
// Requester indices double as the mux select encoding {S_1,S_0}.
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [1:0] IDX_A = 2'd0;
    localparam logic [1:0] IDX_B = 2'd1;
    localparam logic [1:0] IDX_C = 2'd2;
    localparam logic [1:0] IDX_D = 2'd3;

    localparam int unsigned HCNT_W = 8;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set bit of i_req searching from i_start upward,
// wrapping mod 4.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [1:0] i_start,
    output logic       o_found,
    output logic [1:0] o_idx
);

    logic [7:0] w_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_off;

    // w_rot[j] holds i_req[(i_start + j) mod 4]
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_start +: 4];

    always_comb begin
        w_off = IDX_A;
        if (w_rot[0]) begin
            w_off = IDX_A;
        end else if (w_rot[1]) begin
            w_off = IDX_B;
        end else if (w_rot[2]) begin
            w_off = IDX_C;
        end else if (w_rot[3]) begin
            w_off = IDX_D;
        end
    end

    assign o_found = |w_rot;
    assign o_idx   = i_start + w_off;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux among four requesters with a bounded hold time.
// Grant and select are registered together so they always change on the same edge.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       S_1,
    output logic       S_0,
    output logic       busy
);

    localparam logic [HCNT_W-1:0] LP_MAX_HOLD = HCNT_W'(MAX_HOLD);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [3:0]        r_gnt;
    logic [3:0]        w_gnt_nxt;
    logic [1:0]        r_sel;
    logic [1:0]        w_sel_nxt;
    logic [1:0]        r_ptr;
    logic [1:0]        w_ptr_nxt;
    logic [HCNT_W-1:0] r_hcnt;
    logic [HCNT_W-1:0] w_hcnt_nxt;

    logic       w_own_req;
    logic       w_others;
    logic       w_hold_expired;
    logic       w_load;
    logic [3:0] w_pick_req;
    logic       w_pick_found;
    logic [1:0] w_pick_idx;

    // While granted, r_sel is the owner and r_ptr is owner+1, so one picker
    // serves both the idle search and the handover search.
    assign w_own_req      = req[r_sel];
    assign w_others       = |(req & ~r_gnt);
    assign w_hold_expired = (r_hcnt >= LP_MAX_HOLD);
    assign w_pick_req     = (r_state == GRANT) ? (req & ~r_gnt) : req;

    rr_pick4 u_pick (
        .i_req   (w_pick_req),
        .i_start (r_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= IDX_A;
            r_ptr   <= IDX_A;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hcnt  <= w_hcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = GRANT;
                    w_load      = 1'b1;
                end
            end
            GRANT: begin
                if (!w_own_req) begin
                    if (w_others) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_hold_expired && w_others) begin
                    w_load = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Select holds its last value while idle to avoid toggling the mux.
    always_comb begin
        w_gnt_nxt  = r_gnt;
        w_sel_nxt  = r_sel;
        w_ptr_nxt  = r_ptr;
        w_hcnt_nxt = r_hcnt;
        if (w_load) begin
            w_gnt_nxt  = idx_to_onehot(w_pick_idx);
            w_sel_nxt  = w_pick_idx;
            w_ptr_nxt  = w_pick_idx + 2'd1;
            w_hcnt_nxt = HCNT_W'(1);
        end else if (w_state_nxt == IDLE) begin
            w_gnt_nxt  = 4'b0000;
            w_hcnt_nxt = '0;
        end else if (!w_hold_expired) begin
            w_hcnt_nxt = r_hcnt + HCNT_W'(1);
        end
    end

    assign gnt  = r_gnt;
    assign S_1  = r_sel[1];
    assign S_0  = r_sel[0];
    assign busy = |r_gnt;

    ap_max_hold_legal: assert property (@(posedge clk) (MAX_HOLD >= 1) && (MAX_HOLD <= 255))
        else $error("MAX_HOLD out of range 1..255");

    ap_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt))
        else $error("gnt is not one-hot");

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus random traffic,
// compared against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       S_1;
    logic       S_0;
    logic       busy;

    int checks;
    int errors;

    // Model state: owner -1 means idle.
    int m_owner;
    int m_ptr;
    int m_hold;
    int m_sel;

    mux4_rr_arbiter #(
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .S_1  (S_1),
        .S_0  (S_0),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_sel   = 0;
    endtask

    task automatic model_grant(input int k);
        m_owner = k;
        m_sel   = k;
        m_ptr   = (k + 1) % 4;
        m_hold  = 1;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] oth;
        if (m_owner < 0) begin
            if (r != 4'b0000) model_grant(pick(r, m_ptr));
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                if (oth != 4'b0000) begin
                    model_grant(pick(oth, m_owner + 1));
                end else begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end else if (m_hold == MAX_HOLD && oth != 4'b0000) begin
                model_grant(pick(oth, m_owner + 1));
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end
    endtask

    // Apply r for one edge, advance the model, then settle just past the edge.
    task automatic tick(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gnt !== 4'b0000 || {S_1, S_0} !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: gnt=%b S=%b busy=%b required gnt=0000 S=00 busy=0",
                     gnt, {S_1, S_0}, busy);
        end
        rst = 1'b0;
        model_reset();
        tick(4'b1111);
        checks++;
        if (gnt !== 4'b0001 || {S_1, S_0} !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b S=%b busy=%b required gnt=0001 S=00 busy=1",
                     gnt, {S_1, S_0}, busy);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] want;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(4'b1111);
            want = 4'b0001 << ((i / MAX_HOLD) % 4);
            checks++;
            if (gnt !== want || {S_1, S_0} !== 2'((i / MAX_HOLD) % 4) || busy !== 1'b1) begin
                errors++;
                $display("FAIL fairness cyc %0d: gnt=%b S=%b busy=%b required gnt=%b busy=1",
                         i, gnt, {S_1, S_0}, busy, want);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        tick(4'b0101);
        tick(4'b0101);
        checks++;
        if (gnt !== 4'b0001 || {S_1, S_0} !== 2'b00) begin
            errors++;
            $display("FAIL early_release_hold: gnt=%b S=%b required gnt=0001 S=00",
                     gnt, {S_1, S_0});
        end
        tick(4'b0100);
        checks++;
        if (gnt !== 4'b0100 || {S_1, S_0} !== 2'b10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL early_release_switch: gnt=%b S=%b busy=%b required gnt=0100 S=10",
                     gnt, {S_1, S_0}, busy);
        end
    endtask

    task automatic test_sole();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(4'b1000);
            checks++;
            if (gnt !== 4'b1000 || {S_1, S_0} !== 2'b11 || busy !== 1'b1) begin
                errors++;
                $display("FAIL sole cyc %0d: gnt=%b S=%b busy=%b required gnt=1000 S=11 busy=1",
                         i, gnt, {S_1, S_0}, busy);
            end
        end
        checks++;
        if (dut.r_hcnt !== 8'(MAX_HOLD)) begin
            errors++;
            $display("FAIL sole_hcnt_sat: hcnt=%0d required %0d", dut.r_hcnt, MAX_HOLD);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(4'b1000);
        tick(4'b0011);
        checks++;
        if (gnt !== 4'b0001 || {S_1, S_0} !== 2'b00) begin
            errors++;
            $display("FAIL ptr_wrap: gnt=%b S=%b required gnt=0001 S=00", gnt, {S_1, S_0});
        end
        tick(4'b0000);
        tick(4'b0000);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || {S_1, S_0} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_release: gnt=%b S=%b busy=%b required gnt=0000 S=00 busy=0",
                     gnt, {S_1, S_0}, busy);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(4'b0100);
        tick(4'b0110);
        checks++;
        if (gnt !== 4'b0100 || {S_1, S_0} !== 2'b10) begin
            errors++;
            $display("FAIL async_pre: gnt=%b S=%b required gnt=0100 S=10", gnt, {S_1, S_0});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || {S_1, S_0} !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: gnt=%b S=%b busy=%b required gnt=0000 S=00 busy=0",
                     gnt, {S_1, S_0}, busy);
        end
        #1;
        rst = 1'b0;
        model_reset();
        tick(4'b1111);
        checks++;
        if (gnt !== 4'b0001 || {S_1, S_0} !== 2'b00) begin
            errors++;
            $display("FAIL async_rearb: gnt=%b S=%b required gnt=0001 S=00", gnt, {S_1, S_0});
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            tick(r);
            checks++;
            if (gnt !== exp_gnt() || {S_1, S_0} !== 2'(m_sel) || busy !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL random cyc %0d req=%b: gnt=%b S=%b busy=%b required gnt=%b S=%0d",
                         i, r, gnt, {S_1, S_0}, busy, exp_gnt(), m_sel);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        model_reset();
        #3;
        test_reset();
        test_fairness();
        test_early_release();
        test_sole();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
